// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer sharing the single-ported main memory between the
// I-cache (line refills) and the D-cache (line refills or strobed writes).
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned ADDR_WIDTH       = 64,
    parameter int unsigned CACHE_LINE_WIDTH = 256,
    parameter int unsigned TIMEOUT_CYCLES   = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,

    input  logic                        i_i_req,
    input  logic [ADDR_WIDTH-1:0]       i_i_addr,
    output logic                        o_i_done,
    output logic [CACHE_LINE_WIDTH-1:0] o_i_line,

    input  logic                        i_d_req,
    input  logic                        i_d_we,
    input  logic [ADDR_WIDTH-1:0]       i_d_addr,
    input  logic [DATA_WIDTH-1:0]       i_d_wdata,
    input  logic [7:0]                  i_d_strb,
    output logic                        o_d_done,
    output logic [CACHE_LINE_WIDTH-1:0] o_d_line,

    output logic                        o_mem_read_req,
    output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
    input  logic                        i_mem_read_done,
    input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line,
    output logic                        o_mem_write_valid,
    output logic [ADDR_WIDTH-1:0]       o_mem_write_address,
    output logic [DATA_WIDTH-1:0]       o_mem_write_data,
    output logic [7:0]                  o_write_strobe,
    input  logic                        i_mem_write_done,

    output logic                        o_busy,
    output logic                        o_timeout
);

    localparam int unsigned LINE_BYTES = CACHE_LINE_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        I_WAIT,
        D_RD_WAIT,
        D_WR_WAIT,
        RESP
    } state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } port_t;

    state_t          state;
    port_t           last_grant;
    logic [WD_W-1:0] wdog;
    logic            grant_i;
    logic            wd_expired;

    // On a tie the port that did not win last time gets the memory.
    always_comb begin
        grant_i    = i_i_req && (!i_d_req || last_grant == GRANT_D);
        wd_expired = (wdog == WD_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state               <= IDLE;
            last_grant          <= GRANT_D;
            wdog                <= '0;
            o_i_done            <= 1'b0;
            o_i_line            <= '0;
            o_d_done            <= 1'b0;
            o_d_line            <= '0;
            o_mem_read_req      <= 1'b0;
            o_mem_read_address  <= '0;
            o_mem_write_valid   <= 1'b0;
            o_mem_write_address <= '0;
            o_mem_write_data    <= '0;
            o_write_strobe      <= '0;
            o_busy              <= 1'b0;
            o_timeout           <= 1'b0;
        end else begin
            o_mem_read_req    <= 1'b0;
            o_mem_write_valid <= 1'b0;
            o_i_done          <= 1'b0;
            o_d_done          <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_i) begin
                        last_grant         <= GRANT_I;
                        wdog               <= '0;
                        o_busy             <= 1'b1;
                        o_mem_read_address <= i_i_addr & ~OFFSET_MASK;
                        o_mem_read_req     <= 1'b1;
                        state              <= I_WAIT;
                    end else if (i_d_req) begin
                        last_grant <= GRANT_D;
                        wdog       <= '0;
                        o_busy     <= 1'b1;
                        if (i_d_we) begin
                            o_mem_write_address <= i_d_addr;
                            o_mem_write_data    <= i_d_wdata;
                            o_write_strobe      <= i_d_strb;
                            o_mem_write_valid   <= 1'b1;
                            state               <= D_WR_WAIT;
                        end else begin
                            o_mem_read_address <= i_d_addr & ~OFFSET_MASK;
                            o_mem_read_req     <= 1'b1;
                            state              <= D_RD_WAIT;
                        end
                    end
                end

                I_WAIT: begin
                    if (i_mem_read_done) begin
                        o_i_line <= i_cache_line;
                        o_i_done <= 1'b1;
                        state    <= RESP;
                    end else if (wd_expired) begin
                        o_i_done  <= 1'b1;
                        o_timeout <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end

                D_RD_WAIT: begin
                    if (i_mem_read_done) begin
                        o_d_line <= i_cache_line;
                        o_d_done <= 1'b1;
                        state    <= RESP;
                    end else if (wd_expired) begin
                        o_d_done  <= 1'b1;
                        o_timeout <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end

                D_WR_WAIT: begin
                    if (i_mem_write_done) begin
                        o_d_done <= 1'b1;
                        state    <= RESP;
                    end else if (wd_expired) begin
                        o_d_done  <= 1'b1;
                        o_timeout <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end

                RESP: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single transactions, round-robin, back-to-back
// refills, watchdog abort and reset mid-transaction.
module tb_mem_arbiter;

    logic         i_clk;
    logic         i_rst;
    logic         i_i_req;
    logic [63:0]  i_i_addr;
    logic         o_i_done;
    logic [255:0] o_i_line;
    logic         i_d_req;
    logic         i_d_we;
    logic [63:0]  i_d_addr;
    logic [63:0]  i_d_wdata;
    logic [7:0]   i_d_strb;
    logic         o_d_done;
    logic [255:0] o_d_line;
    logic         o_mem_read_req;
    logic [63:0]  o_mem_read_address;
    logic         i_mem_read_done;
    logic [255:0] i_cache_line;
    logic         o_mem_write_valid;
    logic [63:0]  o_mem_write_address;
    logic [63:0]  o_mem_write_data;
    logic [7:0]   o_write_strobe;
    logic         i_mem_write_done;
    logic         o_busy;
    logic         o_timeout;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [255:0] exp_i_line;
    logic [255:0] exp_d_line;

    mem_arbiter #(
        .DATA_WIDTH      (64),
        .ADDR_WIDTH      (64),
        .CACHE_LINE_WIDTH(256),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_i_req            (i_i_req),
        .i_i_addr           (i_i_addr),
        .o_i_done           (o_i_done),
        .o_i_line           (o_i_line),
        .i_d_req            (i_d_req),
        .i_d_we             (i_d_we),
        .i_d_addr           (i_d_addr),
        .i_d_wdata          (i_d_wdata),
        .i_d_strb           (i_d_strb),
        .o_d_done           (o_d_done),
        .o_d_line           (o_d_line),
        .o_mem_read_req     (o_mem_read_req),
        .o_mem_read_address (o_mem_read_address),
        .i_mem_read_done    (i_mem_read_done),
        .i_cache_line       (i_cache_line),
        .o_mem_write_valid  (o_mem_write_valid),
        .o_mem_write_address(o_mem_write_address),
        .o_mem_write_data   (o_mem_write_data),
        .o_write_strobe     (o_write_strobe),
        .i_mem_write_done   (i_mem_write_done),
        .o_busy             (o_busy),
        .o_timeout          (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    // One read transaction with both requests pending; exp_i selects the expected winner.
    task automatic rr_xact(input logic exp_i, input logic [255:0] line, input logic rearm);
        tick();
        check("rr_req", o_mem_read_req, 1'b1);
        check("rr_addr", o_mem_read_address, exp_i ? 64'h100 : 64'h2000);
        tick();
        i_mem_read_done = 1'b1;
        i_cache_line    = line;
        tick();
        i_mem_read_done = 1'b0;
        check("rr_idone", o_i_done, exp_i);
        check("rr_ddone", o_d_done, !exp_i);
        if (exp_i) check("rr_iline", o_i_line, line);
        else       check("rr_dline", o_d_line, line);
        if (exp_i) i_i_req = 1'b0;
        else       i_d_req = 1'b0;
        tick();
        check("rr_idle", o_busy, 1'b0);
        if (rearm) begin
            if (exp_i) i_i_req = 1'b1;
            else       i_d_req = 1'b1;
        end
    endtask

    initial begin
        int unsigned n;
        logic        got;

        i_rst = 1'b1;
        i_i_req = 1'b0; i_i_addr = '0;
        i_d_req = 1'b0; i_d_we = 1'b0; i_d_addr = '0; i_d_wdata = '0; i_d_strb = '0;
        i_mem_read_done = 1'b0; i_mem_write_done = 1'b0; i_cache_line = '0;
        exp_i_line = '0;
        exp_d_line = '0;
        do_reset();

        check("rst_busy", o_busy, 1'b0);
        check("rst_rdreq", o_mem_read_req, 1'b0);
        check("rst_rdaddr", o_mem_read_address, 64'h0);
        check("rst_iline", o_i_line, 256'h0);
        check("rst_timeout", o_timeout, 1'b0);

        // I-cache refill, address aligned down to the 32-byte line.
        i_i_req  = 1'b1;
        i_i_addr = 64'h1234;
        tick();
        check("i_req_pulse", o_mem_read_req, 1'b1);
        check("i_rdaddr", o_mem_read_address, 64'h1220);
        check("i_busy", o_busy, 1'b1);
        tick();
        check("i_req_drop", o_mem_read_req, 1'b0);
        check("i_done_early", o_i_done, 1'b0);
        i_mem_read_done = 1'b1;
        i_cache_line    = {4{64'h1111_2222_3333_4444}};
        exp_i_line      = {4{64'h1111_2222_3333_4444}};
        tick();
        i_mem_read_done = 1'b0;
        i_i_req         = 1'b0;
        check("i_done", o_i_done, 1'b1);
        check("i_line", o_i_line, exp_i_line);
        check("i_d_quiet", o_d_done, 1'b0);
        tick();
        check("i_done_pulse", o_i_done, 1'b0);
        check("i_idle", o_busy, 1'b0);

        // D-cache strobed write; the address passes through unmasked.
        i_d_req   = 1'b1;
        i_d_we    = 1'b1;
        i_d_addr  = 64'h40;
        i_d_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
        i_d_strb  = 8'h0F;
        tick();
        check("w_valid", o_mem_write_valid, 1'b1);
        check("w_rdreq", o_mem_read_req, 1'b0);
        check("w_addr", o_mem_write_address, 64'h40);
        check("w_data", o_mem_write_data, 64'hA5A5_A5A5_A5A5_A5A5);
        check("w_strb", o_write_strobe, 8'h0F);
        tick();
        check("w_valid_drop", o_mem_write_valid, 1'b0);
        // A read-done during a write wait must not complete it.
        i_mem_read_done = 1'b1;
        tick();
        i_mem_read_done  = 1'b0;
        check("w_wrong_done", o_d_done, 1'b0);
        i_mem_write_done = 1'b1;
        tick();
        i_mem_write_done = 1'b0;
        i_d_req          = 1'b0;
        check("w_done", o_d_done, 1'b1);
        check("w_dline", o_d_line, exp_d_line);
        tick();
        check("w_done_pulse", o_d_done, 1'b0);
        check("w_hold_addr", o_mem_write_address, 64'h40);

        // Simultaneous requests from reset alternate I, D, I, D.
        do_reset();
        i_d_we   = 1'b0;
        i_i_addr = 64'h100;
        i_d_addr = 64'h2000;
        i_i_req  = 1'b1;
        i_d_req  = 1'b1;
        rr_xact(1'b1, {4{64'hAAAA_0000_0000_0001}}, 1'b1);
        rr_xact(1'b0, {4{64'hBBBB_0000_0000_0002}}, 1'b1);
        rr_xact(1'b1, {4{64'hCCCC_0000_0000_0003}}, 1'b1);
        rr_xact(1'b0, {4{64'hDDDD_0000_0000_0004}}, 1'b0);
        i_i_req = 1'b0;
        i_d_req = 1'b0;
        exp_i_line = {4{64'hCCCC_0000_0000_0003}};
        tick();
        tick();

        // D read held continuously: a new grant every 4 cycles.
        i_d_req  = 1'b1;
        i_d_addr = 64'h3045;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bb_req", o_mem_read_req, 1'b1);
            check("bb_addr", o_mem_read_address, 64'h3040);
            tick();
            i_mem_read_done = 1'b1;
            i_cache_line    = {8{k[31:0] + 32'h5000_0000}};
            tick();
            i_mem_read_done = 1'b0;
            check("bb_done", o_d_done, 1'b1);
            check("bb_line", o_d_line, {8{k[31:0] + 32'h5000_0000}});
            tick();
            check("bb_gap", o_mem_read_req | o_d_done, 1'b0);
        end
        i_d_req = 1'b0;
        exp_d_line = {8{32'h5000_0002}};
        tick();
        tick();

        // Memory never answers: abort after 16 wait cycles.
        check("to_pre", o_timeout, 1'b0);
        i_i_req  = 1'b1;
        i_i_addr = 64'h40;
        tick();
        check("to_req", o_mem_read_req, 1'b1);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            tick();
            n++;
            if (o_i_done) got = 1'b1;
        end
        i_i_req = 1'b0;
        check("to_latency", n, 16);
        check("to_flag", o_timeout, 1'b1);
        check("to_iline", o_i_line, exp_i_line);
        check("to_ddone", o_d_done, 1'b0);
        tick();
        check("to_idle", o_busy, 1'b0);
        // Stale done in IDLE is ignored; the timeout flag stays set.
        i_mem_read_done = 1'b1;
        tick();
        i_mem_read_done = 1'b0;
        tick();
        check("stale_idone", o_i_done, 1'b0);
        check("stale_busy", o_busy, 1'b0);
        check("to_sticky", o_timeout, 1'b1);

        // Reset in I_WAIT followed by a stale read-done.
        i_i_req  = 1'b1;
        i_i_addr = 64'h8000;
        tick();
        check("rw_busy", o_busy, 1'b1);
        i_rst = 1'b1;
        tick();
        i_rst           = 1'b0;
        i_i_req         = 1'b0;
        i_mem_read_done = 1'b1;
        i_cache_line    = {4{64'hDEAD_BEEF_DEAD_BEEF}};
        tick();
        i_mem_read_done = 1'b0;
        check("rw_idone", o_i_done, 1'b0);
        check("rw_busy0", o_busy, 1'b0);
        check("rw_iline", o_i_line, 256'h0);
        check("rw_addr", o_mem_read_address, 64'h0);
        check("rw_timeout", o_timeout, 1'b0);
        tick();
        check("rw_idone2", o_i_done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
